// File: rtl/beep_arbiter_if.sv
// beep_arbiter_if: request/status bundle between the tone requesters and the buzzer arbiter.
// The master side raises request pulses and mute; the slave side (the arbiter) reports
// buzzer drive, busy, the served requester and the grant/done pulses.
interface beep_arbiter_if;
  logic [3:0] req;
  logic       mute;
  logic       beep;
  logic       busy;
  logic [1:0] active_id;
  logic [3:0] grant;
  logic [3:0] done;

  modport master (
    output req, mute,
    input  beep, busy, active_id, grant, done
  );

  modport slave (
    input  req, mute,
    output beep, busy, active_id, grant, done
  );
endinterface

// File: rtl/beep_arbiter.sv
// beep_arbiter: shares one buzzer between four tone requesters.
// One-cycle request pulses latch into pending bits and are served one at a time,
// highest index first, each as a square-wave burst of fixed pitch and length
// followed by a silent gap. A higher-priority request preempts a running tone.
// Build macro BEEP_ARB_REQUEUE_EN: when defined, a preempted requester is put back
// into pending and later replays its full tone; when undefined it is dropped.
module beep_arbiter #(
  parameter int unsigned MS_CNT = 50000,
  parameter int unsigned DIV0   = 12500,
  parameter int unsigned DIV1   = 19000,
  parameter int unsigned DIV2   = 25000,
  parameter int unsigned DIV3   = 9500,
  parameter int unsigned DUR0   = 50,
  parameter int unsigned DUR1   = 150,
  parameter int unsigned DUR2   = 400,
  parameter int unsigned DUR3   = 800,
  parameter int unsigned GAP_MS = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  beep_arbiter_if.slave bus
);

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..maxVal-1, never less than one.
  function automatic int unsigned widthFor(input int unsigned maxVal);
    return (maxVal > 1) ? int'($clog2(maxVal)) : 1;
  endfunction

  localparam int unsigned DIV_MAX = maxOf(maxOf(DIV0, DIV1), maxOf(DIV2, DIV3));
  localparam int unsigned DUR_MAX = maxOf(maxOf(maxOf(DUR0, DUR1), maxOf(DUR2, DUR3)), GAP_MS);
  localparam int unsigned HW      = widthFor(DIV_MAX);
  localparam int unsigned MW      = widthFor(MS_CNT);
  localparam int unsigned DW      = widthFor(DUR_MAX);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;

  // Last half-period count for the given requester (toggle point).
  function automatic logic [HW-1:0] halfLast(input logic [1:0] id);
    case (id)
      2'd0:    halfLast = HW'(DIV0 - 1);
      2'd1:    halfLast = HW'(DIV1 - 1);
      2'd2:    halfLast = HW'(DIV2 - 1);
      default: halfLast = HW'(DIV3 - 1);
    endcase
  endfunction

  // Duration counter reload for the given requester: tone length in ms minus one.
  function automatic logic [DW-1:0] durLast(input logic [1:0] id);
    case (id)
      2'd0:    durLast = DW'(DUR0 - 1);
      2'd1:    durLast = DW'(DUR1 - 1);
      2'd2:    durLast = DW'(DUR2 - 1);
      default: durLast = DW'(DUR3 - 1);
    endcase
  endfunction

  state_e        state_q,    state_d;
  logic [3:0]    pending_q,  pending_d;
  logic [1:0]    activeId_q, activeId_d;
  logic [HW-1:0] hpCnt_q,    hpCnt_d;
  logic [MW-1:0] msCnt_q,    msCnt_d;
  logic [DW-1:0] durCnt_q,   durCnt_d;
  logic          toneBit_q,  toneBit_d;
  logic          beep_q,     beep_d;
  logic [3:0]    grant_q,    grant_d;
  logic [3:0]    done_q,     done_d;

  logic [3:0]    reqSet;
  logic [3:0]    clrMask;
  logic [3:0]    requeue;
  logic          hiValid;
  logic [1:0]    hiIdx;
  logic          doGrant;
  logic          msWrap;

  // Register all state; reset silences the buzzer and forgets every request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      activeId_q <= '0;
      hpCnt_q    <= '0;
      msCnt_q    <= '0;
      durCnt_q   <= '0;
      toneBit_q  <= 1'b0;
      beep_q     <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      activeId_q <= activeId_d;
      hpCnt_q    <= hpCnt_d;
      msCnt_q    <= msCnt_d;
      durCnt_q   <= durCnt_d;
      toneBit_q  <= toneBit_d;
      beep_q     <= beep_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  // Arbitration, tone/gap timing and pending bookkeeping for the next edge.
  always_comb begin
    state_d    = state_q;
    activeId_d = activeId_q;
    hpCnt_d    = hpCnt_q;
    msCnt_d    = msCnt_q;
    durCnt_d   = durCnt_q;
    toneBit_d  = toneBit_q;
    grant_d    = '0;
    done_d     = '0;
    clrMask    = '0;
    requeue    = '0;
    doGrant    = 1'b0;
    hiValid    = 1'b0;
    hiIdx      = 2'd0;
    msWrap     = (msCnt_q == MW'(MS_CNT - 1));

    // A request from the requester already playing is a retrigger, not a new request.
    reqSet = bus.req;
    if (state_q == TONE) begin
      reqSet[activeId_q] = 1'b0;
    end

    for (int k = 0; k < 4; k++) begin
      if (pending_q[k]) begin
        hiValid = 1'b1;
        hiIdx   = 2'(k);
      end
    end

    case (state_q)
      IDLE: begin
        if (hiValid) begin
          doGrant = 1'b1;
        end
      end

      TONE: begin
        if (hiValid && (hiIdx > activeId_q)) begin
          doGrant = 1'b1;
`ifdef BEEP_ARB_REQUEUE_EN
          requeue[activeId_q] = 1'b1;
`endif
        end else begin
          if (hpCnt_q == halfLast(activeId_q)) begin
            hpCnt_d   = '0;
            toneBit_d = ~toneBit_q;
          end else begin
            hpCnt_d = hpCnt_q + 1'b1;
          end

          if (bus.req[activeId_q]) begin
            msCnt_d  = '0;
            durCnt_d = durLast(activeId_q);
          end else if (msWrap) begin
            msCnt_d = '0;
            if (durCnt_q == '0) begin
              state_d             = GAP;
              done_d[activeId_q]  = 1'b1;
              toneBit_d           = 1'b0;
              hpCnt_d             = '0;
              durCnt_d            = DW'(GAP_MS - 1);
            end else begin
              durCnt_d = durCnt_q - 1'b1;
            end
          end else begin
            msCnt_d = msCnt_q + 1'b1;
          end
        end
      end

      GAP: begin
        if (msWrap) begin
          msCnt_d = '0;
          if (durCnt_q == '0) begin
            state_d = IDLE;
          end else begin
            durCnt_d = durCnt_q - 1'b1;
          end
        end else begin
          msCnt_d = msCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (doGrant) begin
      state_d         = TONE;
      activeId_d      = hiIdx;
      grant_d[hiIdx]  = 1'b1;
      clrMask[hiIdx]  = 1'b1;
      hpCnt_d         = '0;
      toneBit_d       = 1'b1;
      msCnt_d         = '0;
      durCnt_d        = durLast(hiIdx);
    end

    pending_d = (pending_q & ~clrMask) | reqSet | requeue;
    beep_d    = toneBit_d & (state_d == TONE) & ~bus.mute;
  end

  assign bus.beep      = beep_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.active_id = activeId_q;
  assign bus.grant     = grant_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_beep_arbiter.sv
// tb_beep_arbiter: self-checking bench for beep_arbiter with small timing parameters.
// A reference model tracks the arbiter as "cycles remaining" and "cycles since grant"
// and predicts every output each cycle; scenario tasks add explicit timing checks.
`timescale 1ns/1ps
module tb_beep_arbiter;

  localparam int MS  = 10;
  localparam int GAP = 2;

  int divs [4] = '{2, 3, 4, 5};
  int durs [4] = '{3, 2, 2, 4};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  beep_arbiter_if bus();

  beep_arbiter #(
    .MS_CNT(MS), .DIV0(2), .DIV1(3), .DIV2(4), .DIV3(5),
    .DUR0(3), .DUR1(2), .DUR2(2), .DUR3(4), .GAP_MS(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: mode 0 idle, 1 tone, 2 gap.
  logic [3:0] mPend;
  int         mMode;
  logic [1:0] mId;
  int         mRemain;
  int         mElapsed;
  logic [3:0] eGrant;
  logic [3:0] eDone;
  logic       eBeep;

  logic [12:0] obs;
  logic [12:0] expv;
  assign obs  = {bus.beep, bus.busy, bus.active_id, bus.grant, bus.done};
  assign expv = {eBeep, (mMode != 0), mId, eGrant, eDone};

  task automatic model_reset();
    mPend = '0; mMode = 0; mId = '0; mRemain = 0; mElapsed = 0;
    eGrant = '0; eDone = '0; eBeep = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs seen during the cycle.
  task automatic model_step(input logic [3:0] r, input logic m);
    int g;
    int hi;
    logic [3:0] reqEff;
    logic [3:0] clr;
    logic [3:0] rq;
    logic retrig;
    g = -1; hi = -1; reqEff = r; clr = '0; rq = '0; retrig = 1'b0;
    eGrant = '0; eDone = '0;
    for (int k = 0; k < 4; k++) if (mPend[k]) hi = k;
    if (mMode == 1) begin
      retrig = r[mId];
      reqEff[mId] = 1'b0;
    end
    case (mMode)
      0: if (hi >= 0) g = hi;
      1: begin
        if (hi > int'(mId)) begin
          g = hi;
`ifdef BEEP_ARB_REQUEUE_EN
          rq[mId] = 1'b1;
`endif
        end else begin
          mElapsed++;
          if (retrig) mRemain = durs[mId] * MS;
          else if (mRemain == 1) begin
            eDone[mId] = 1'b1;
            mMode = 2;
            mRemain = GAP * MS;
          end else mRemain--;
        end
      end
      default: begin
        if (mRemain == 1) mMode = 0;
        else mRemain--;
      end
    endcase
    if (g >= 0) begin
      mMode = 1; mId = 2'(g); mRemain = durs[g] * MS; mElapsed = 0;
      eGrant[g] = 1'b1; clr[g] = 1'b1;
    end
    mPend = (mPend & ~clr) | reqEff | rq;
    eBeep = (mMode == 1) && (((mElapsed / divs[mId]) % 2) == 0) && !m;
  endtask

  // Drive inputs for one cycle, clock the DUT and the model, then settle past the edge.
  task automatic tick(input logic [3:0] r, input logic m);
    bus.req  = r;
    bus.mute = m;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, m);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(4'b1111, 1'b0);
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d got %b want %b", c, obs, 13'd0);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d got %b want %b", c, obs, 13'd0);
      end
    end
  endtask

  task automatic test_single();
    int grantAt, doneAt, idleAt;
    grantAt = -1; doneAt = -1; idleAt = -1;
    for (int c = 1; c <= 60; c++) begin
      tick((c == 1) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL single cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant[0] && grantAt < 0) grantAt = c;
      if (bus.done[0] && doneAt < 0) doneAt = c;
      if (grantAt >= 0 && !bus.busy && idleAt < 0) idleAt = c;
    end
    checks++;
    if (grantAt !== 2) begin errors++; $display("[TB] FAIL single_grant_at got %0d want 2", grantAt); end
    checks++;
    if (doneAt !== 32) begin errors++; $display("[TB] FAIL single_done_at got %0d want 32", doneAt); end
    checks++;
    if (idleAt !== 52) begin errors++; $display("[TB] FAIL single_idle_at got %0d want 52", idleAt); end
  endtask

  task automatic test_multi();
    int g2, d2, g0, d0, nd2, nd0;
    g2 = -1; d2 = -1; g0 = -1; d0 = -1; nd2 = 0; nd0 = 0;
    for (int c = 1; c <= 100; c++) begin
      tick((c == 1) ? 4'b0101 : 4'b0000, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL multi cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant[2] && g2 < 0) g2 = c;
      if (bus.grant[0] && g0 < 0) g0 = c;
      if (bus.done[2]) begin nd2++; if (d2 < 0) d2 = c; end
      if (bus.done[0]) begin nd0++; if (d0 < 0) d0 = c; end
    end
    checks++;
    if (g2 !== 2) begin errors++; $display("[TB] FAIL multi_grant2_at got %0d want 2", g2); end
    checks++;
    if (d2 !== 22) begin errors++; $display("[TB] FAIL multi_done2_at got %0d want 22", d2); end
    checks++;
    if (g0 !== 43) begin errors++; $display("[TB] FAIL multi_grant0_at got %0d want 43", g0); end
    checks++;
    if (d0 !== 73) begin errors++; $display("[TB] FAIL multi_done0_at got %0d want 73", d0); end
    checks++;
    if (nd2 !== 1 || nd0 !== 1) begin
      errors++;
      $display("[TB] FAIL multi_done_counts got %0d/%0d want 1/1", nd2, nd0);
    end
  endtask

  task automatic test_preempt();
    int g3, nGrant0, nDone0Early, g0Second;
    g3 = -1; nGrant0 = 0; nDone0Early = 0; g0Second = -1;
    for (int c = 1; c <= 130; c++) begin
      tick((c == 1) ? 4'b0001 : ((c == 11) ? 4'b1000 : 4'b0000), 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL preempt cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant[3] && g3 < 0) g3 = c;
      if (bus.grant[0]) begin
        nGrant0++;
        if (nGrant0 == 2) g0Second = c;
      end
      if (bus.done[0] && g3 < 0) nDone0Early++;
    end
    checks++;
    if (g3 !== 12) begin errors++; $display("[TB] FAIL preempt_grant3_at got %0d want 12", g3); end
    checks++;
    if (nDone0Early !== 0) begin errors++; $display("[TB] FAIL preempt_no_done0 got %0d want 0", nDone0Early); end
`ifdef BEEP_ARB_REQUEUE_EN
    checks++;
    if (g0Second !== 73) begin errors++; $display("[TB] FAIL preempt_requeue_at got %0d want 73", g0Second); end
`else
    checks++;
    if (nGrant0 !== 1) begin errors++; $display("[TB] FAIL preempt_drop_grants got %0d want 1", nGrant0); end
`endif
  endtask

  task automatic test_retrigger();
    int gAt, dAt, nGrant;
    gAt = -1; dAt = -1; nGrant = 0;
    for (int c = 1; c <= 75; c++) begin
      tick((c == 1 || c == 17) ? 4'b0001 : 4'b0000, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL retrigger cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant[0]) begin nGrant++; if (gAt < 0) gAt = c; end
      if (bus.done[0] && dAt < 0) dAt = c;
    end
    checks++;
    if ((dAt - gAt) !== 45) begin errors++; $display("[TB] FAIL retrigger_length got %0d want 45", dAt - gAt); end
    checks++;
    if (nGrant !== 1) begin errors++; $display("[TB] FAIL retrigger_grants got %0d want 1", nGrant); end
  endtask

  task automatic test_mute();
    int gAt, dAt, beepSeen;
    gAt = -1; dAt = -1; beepSeen = 0;
    for (int c = 1; c <= 60; c++) begin
      tick((c == 1) ? 4'b0001 : 4'b0000, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL mute cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant[0] && gAt < 0) gAt = c;
      if (bus.done[0] && dAt < 0) dAt = c;
      if (bus.beep) beepSeen++;
    end
    checks++;
    if (beepSeen !== 0) begin errors++; $display("[TB] FAIL mute_beep got %0d want 0", beepSeen); end
    checks++;
    if (gAt !== 2 || dAt !== 32) begin
      errors++;
      $display("[TB] FAIL mute_timing got %0d/%0d want 2/32", gAt, dAt);
    end
  endtask

  task automatic test_async_reset();
    int grants;
    grants = 0;
    for (int c = 1; c <= 10; c++) begin
      tick((c == 1) ? 4'b0001 : ((c == 10) ? 4'b1000 : 4'b0000), 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL async_pre cycle %0d got %b want %b", c, obs, expv);
      end
    end
    bus.req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("[TB] FAIL async_immediate got %b want %b", obs, 13'd0);
    end
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    rst_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL async_post cycle %0d got %b want %b", c, obs, expv);
      end
      if (bus.grant !== 4'b0000) grants++;
    end
    checks++;
    if (grants !== 0) begin errors++; $display("[TB] FAIL async_no_replay got %0d want 0", grants); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic m;
    m = 1'b0;
    for (int c = 1; c <= 1500; c++) begin
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) m = ~m;
      tick(r, m);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL random cycle %0d got %b want %b", c, obs, expv);
      end
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.mute = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_multi();
    test_preempt();
    test_retrigger();
    test_mute();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
